tdc_decoder: RTL and testbench

TDC_DECODER -- requirements
Module: tdc_decoder

---
 rtl/tdc_pkg.sv | 19 +
 rtl/tdc_edge_find.sv | 39 +++
 rtl/tdc_decoder.sv | 153 +++++++++++++++
 tb/tb_tdc_decoder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared constants and small helpers for the TDC decoder slice.
package tdc_pkg;

  localparam int TDC_W   = 64;  // default number of TDC taps
  localparam int POS_W   = 6;   // edge position / target width
  localparam int ERR_W   = 7;   // signed phase error width
  localparam int TDC_LAT = 4;   // capture edge to output pulse, in ref_clk cycles

  // Magnitude of a two's-complement phase error (range never reaches -64)
  function automatic logic [ERR_W-1:0] abs_err(input logic [ERR_W-1:0] e);
    return e[ERR_W-1] ? ERR_W'(-e) : e;
  endfunction

  // A programmed lock count of zero behaves like one
  function automatic logic [7:0] lock_goal(input logic [7:0] cnt);
    return (cnt == 8'd0) ? 8'd1 : cnt;
  endfunction

endpackage

// File: rtl/tdc_edge_find.sv
// Combinational rising-edge finder: lowest tap k with bit k=1 and bit k-1=0.
module tdc_edge_find
  import tdc_pkg::*;
#(
  parameter int TDC_W = tdc_pkg::TDC_W
) (
  input  logic [TDC_W-1:0] vec,
  output logic [POS_W-1:0] pos,
  output logic             found
);

  logic [TDC_W-1:0] rise;
  logic [TDC_W-1:0] lowest;

  // Mark every 0->1 transition; tap 0 has no lower neighbour
  genvar gi;
  generate
    for (gi = 0; gi < TDC_W; gi++) begin : g_rise
      if (gi == 0) begin : g_lsb
        assign rise[gi] = 1'b0;
      end else begin : g_tap
        assign rise[gi] = vec[gi] & ~vec[gi-1];
      end
    end
  endgenerate

  // Isolate the lowest transition so multiple edges resolve to the lowest index
  assign lowest = rise & (~rise + TDC_W'(1));
  assign found  = |rise;

  // Encode the one-hot lowest transition into a tap index
  always_comb begin
    pos = '0;
    for (int k = 1; k < TDC_W; k++) begin
      if (lowest[k]) pos = pos | POS_W'(k);
    end
  end

endmodule

// File: rtl/tdc_decoder.sv
// Thermometer TDC decoder: capture, bubble-correct, find edge, phase error and lock.
module tdc_decoder
  import tdc_pkg::*;
#(
  parameter int TDC_W = tdc_pkg::TDC_W
) (
  input  logic             ref_clk,
  input  logic             csr_tdc_rst,
  input  logic [TDC_W-1:0] sampled_tdc,
  input  logic             csr_tdc_en,
  input  logic [POS_W-1:0] csr_tdc_target,
  input  logic [POS_W-1:0] csr_tdc_lock_thr,
  input  logic [7:0]       csr_tdc_lock_cnt,
  output logic [ERR_W-1:0] tdc_phase_err,
  output logic             tdc_valid,
  output logic             tdc_err,
  output logic             tdc_lock
);

  logic [TDC_W-1:0] s1_data_reg;
  logic             s1_tok_reg;
  logic [TDC_W-1:0] bub_data;
  logic [TDC_W-1:0] s2_data_reg;
  logic             s2_tok_reg;
  logic [POS_W-1:0] edge_pos;
  logic             edge_found;
  logic [POS_W-1:0] s3_pos_reg;
  logic             s3_found_reg;
  logic             s3_tok_reg;

  logic [ERR_W-1:0] err_calc;
  logic             in_thr;
  logic [7:0]       cnt_inc;
  logic [ERR_W-1:0] phase_reg, phase_next;
  logic             valid_reg, valid_next;
  logic             err_reg, err_next;
  logic             lock_reg, lock_next;
  logic [7:0]       lock_cnt_reg, lock_cnt_next;

  // S1: plain capture of the asynchronous TDC sample plus its token
  always_ff @(posedge ref_clk or posedge csr_tdc_rst) begin
    if (csr_tdc_rst) begin
      s1_data_reg <= '0;
      s1_tok_reg  <= 1'b0;
    end else begin
      s1_data_reg <= sampled_tdc;
      s1_tok_reg  <= csr_tdc_en;
    end
  end

  // Three-tap majority vote removes single-tap bubbles; end taps pass through
  genvar gi;
  generate
    for (gi = 0; gi < TDC_W; gi++) begin : g_bubble
      if (gi == 0 || gi == TDC_W-1) begin : g_end
        assign bub_data[gi] = s1_data_reg[gi];
      end else begin : g_mid
        assign bub_data[gi] = (s1_data_reg[gi-1] & s1_data_reg[gi])   |
                              (s1_data_reg[gi-1] & s1_data_reg[gi+1]) |
                              (s1_data_reg[gi]   & s1_data_reg[gi+1]);
      end
    end
  endgenerate

  // S2: register the bubble-corrected vector; tokens die when disabled
  always_ff @(posedge ref_clk or posedge csr_tdc_rst) begin
    if (csr_tdc_rst) begin
      s2_data_reg <= '0;
      s2_tok_reg  <= 1'b0;
    end else begin
      s2_data_reg <= bub_data;
      s2_tok_reg  <= s1_tok_reg & csr_tdc_en;
    end
  end

  tdc_edge_find #(
    .TDC_W (TDC_W)
  ) u_edge_find (
    .vec   (s2_data_reg),
    .pos   (edge_pos),
    .found (edge_found)
  );

  // S3: register edge position and found flag
  always_ff @(posedge ref_clk or posedge csr_tdc_rst) begin
    if (csr_tdc_rst) begin
      s3_pos_reg   <= '0;
      s3_found_reg <= 1'b0;
      s3_tok_reg   <= 1'b0;
    end else begin
      s3_pos_reg   <= edge_pos;
      s3_found_reg <= edge_found;
      s3_tok_reg   <= s2_tok_reg & csr_tdc_en;
    end
  end

  // Live CSR target and threshold are used here so changes take effect at once
  assign err_calc = {1'b0, s3_pos_reg} - {1'b0, csr_tdc_target};
  assign in_thr   = abs_err(err_calc) <= {1'b0, csr_tdc_lock_thr};
  assign cnt_inc  = (lock_cnt_reg == 8'hFF) ? 8'hFF : lock_cnt_reg + 8'd1;

  // S4 next state: phase error, pulses and lock tracking
  always_comb begin
    phase_next    = phase_reg;
    valid_next    = 1'b0;
    err_next      = 1'b0;
    lock_next     = lock_reg;
    lock_cnt_next = lock_cnt_reg;
    if (!csr_tdc_en) begin
      lock_next     = 1'b0;
      lock_cnt_next = 8'd0;
    end else if (s3_tok_reg) begin
      if (!s3_found_reg) begin
        err_next      = 1'b1;
        lock_next     = 1'b0;
        lock_cnt_next = 8'd0;
      end else begin
        valid_next = 1'b1;
        phase_next = err_calc;
        if (in_thr) begin
          lock_cnt_next = cnt_inc;
          lock_next     = lock_reg | (cnt_inc >= lock_goal(csr_tdc_lock_cnt));
        end else begin
          lock_next     = 1'b0;
          lock_cnt_next = 8'd0;
        end
      end
    end
  end

  // S4 output and lock registers
  always_ff @(posedge ref_clk or posedge csr_tdc_rst) begin
    if (csr_tdc_rst) begin
      phase_reg    <= '0;
      valid_reg    <= 1'b0;
      err_reg      <= 1'b0;
      lock_reg     <= 1'b0;
      lock_cnt_reg <= 8'd0;
    end else begin
      phase_reg    <= phase_next;
      valid_reg    <= valid_next;
      err_reg      <= err_next;
      lock_reg     <= lock_next;
      lock_cnt_reg <= lock_cnt_next;
    end
  end

  assign tdc_phase_err = phase_reg;
  assign tdc_valid     = valid_reg;
  assign tdc_err       = err_reg;
  assign tdc_lock      = lock_reg;

endmodule

// File: tb/tb_tdc_decoder.sv
// Directed scoreboard bench for tdc_decoder.
module tb_tdc_decoder;
  import tdc_pkg::*;

  logic        ref_clk = 1'b0;
  logic        csr_tdc_rst;
  logic [63:0] sampled_tdc;
  logic        csr_tdc_en;
  logic [5:0]  csr_tdc_target;
  logic [5:0]  csr_tdc_lock_thr;
  logic [7:0]  csr_tdc_lock_cnt;
  logic [6:0]  tdc_phase_err;
  logic        tdc_valid;
  logic        tdc_err;
  logic        tdc_lock;

  tdc_decoder dut (
    .ref_clk          (ref_clk),
    .csr_tdc_rst      (csr_tdc_rst),
    .sampled_tdc      (sampled_tdc),
    .csr_tdc_en       (csr_tdc_en),
    .csr_tdc_target   (csr_tdc_target),
    .csr_tdc_lock_thr (csr_tdc_lock_thr),
    .csr_tdc_lock_cnt (csr_tdc_lock_cnt),
    .tdc_phase_err    (tdc_phase_err),
    .tdc_valid        (tdc_valid),
    .tdc_err          (tdc_err),
    .tdc_lock         (tdc_lock)
  );

  always #5 ref_clk = ~ref_clk;

  typedef struct {
    int         due;
    logic       v;
    logic       e;
    logic [6:0] ph;
    logic       lk;
    logic [6:0] s_ph;
    int         s_cnt;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          edge_cnt = 0;
  logic [6:0]  model_phase = '0;
  int          model_cnt = 0;
  logic        model_lock = 1'b0;
  logic [63:0] last_sample = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, edge_cnt, obs, expv);
    end
  endtask

  function automatic logic [63:0] therm(input int p);
    logic [63:0] ones;
    ones = '1;
    return ones << p;
  endfunction

  function automatic logic [63:0] bubble(input logic [63:0] v);
    logic [63:0] r;
    r = v;
    for (int i = 1; i < 63; i++)
      r[i] = (int'(v[i-1]) + int'(v[i]) + int'(v[i+1])) >= 2;
    return r;
  endfunction

  task automatic find_edge(input logic [63:0] v, output int pos, output bit found);
    pos = 0;
    found = 0;
    for (int k = 63; k >= 1; k--) begin
      if (v[k] && !v[k-1]) begin
        pos = k;
        found = 1;
      end
    end
  endtask

  // One clock: compare the due transaction, otherwise require quiet outputs
  task automatic tick();
    exp_t x;
    @(posedge ref_clk);
    edge_cnt++;
    #1;
    if (q.size() > 0 && q[0].due == edge_cnt) begin
      x = q.pop_front();
      $display("txn @edge %0d: valid=%0b err=%0b phase=%0d lock=%0b (exp %0b %0b %0d %0b)",
               edge_cnt, tdc_valid, tdc_err, $signed(tdc_phase_err), tdc_lock,
               x.v, x.e, $signed(x.ph), x.lk);
      chk("valid", 32'(tdc_valid), 32'(x.v));
      chk("err", 32'(tdc_err), 32'(x.e));
      chk("phase", 32'(tdc_phase_err), 32'(x.ph));
      chk("lock", 32'(tdc_lock), 32'(x.lk));
    end else begin
      chk("idle_valid", 32'(tdc_valid), 32'd0);
      chk("idle_err", 32'(tdc_err), 32'd0);
      if (q.size() == 0) begin
        chk("hold_phase", 32'(tdc_phase_err), 32'(model_phase));
        chk("hold_lock", 32'(tdc_lock), 32'(model_lock));
      end
    end
  endtask

  // Drive one enabled sample and push its expected result
  task automatic drive(input logic [63:0] s);
    exp_t x;
    int   pos, e, mag, goal;
    bit   found;
    csr_tdc_en  = 1'b1;
    sampled_tdc = s;
    last_sample = s;
    find_edge(bubble(s), pos, found);
    x.due   = edge_cnt + TDC_LAT;
    x.s_ph  = model_phase;
    x.s_cnt = model_cnt;
    if (found) begin
      e    = pos - int'(csr_tdc_target);
      mag  = (e < 0) ? -e : e;
      goal = (csr_tdc_lock_cnt == 8'd0) ? 1 : int'(csr_tdc_lock_cnt);
      model_phase = 7'(e);
      if (mag <= int'(csr_tdc_lock_thr)) begin
        model_cnt  = (model_cnt == 255) ? 255 : model_cnt + 1;
        model_lock = model_lock || (model_cnt >= goal);
      end else begin
        model_cnt  = 0;
        model_lock = 1'b0;
      end
      x.v = 1'b1;
      x.e = 1'b0;
    end else begin
      model_cnt  = 0;
      model_lock = 1'b0;
      x.v = 1'b0;
      x.e = 1'b1;
    end
    x.ph = model_phase;
    x.lk = model_lock;
    q.push_back(x);
    tick();
  endtask

  // Drop enable for one clock; anything due at or after that edge is flushed
  task automatic en_low();
    exp_t x;
    int   n;
    csr_tdc_en = 1'b0;
    n = edge_cnt + 1;
    while (q.size() > 0 && q[$].due >= n) begin
      x = q.pop_back();
      model_phase = x.s_ph;
      model_cnt   = x.s_cnt;
    end
    model_cnt  = 0;
    model_lock = 1'b0;
    tick();
  endtask

  // Let real samples emerge behind fillers, then flush the fillers
  task automatic drain();
    repeat (3) drive(last_sample);
    en_low();
  endtask

  initial begin
    csr_tdc_rst      = 1'b1;
    csr_tdc_en       = 1'b0;
    sampled_tdc      = '0;
    csr_tdc_target   = 6'd16;
    csr_tdc_lock_thr = 6'd4;
    csr_tdc_lock_cnt = 8'd1;
    repeat (2) tick();
    csr_tdc_rst = 1'b0;

    // +4 error locks at once with count 1, then no-edge samples clear lock
    drive(64'hFFFF_FFFF_FFF0_0000);
    drive(64'h0);
    drive(64'hFFFF_FFFF_FFFF_FFFF);
    drain();

    // Bubble removal, falling-edge-only, and lowest of multiple edges
    csr_tdc_target = 6'd19;
    drive(64'hFFFF_FFFF_FFF4_0000);
    drive(64'h0000_0000_FFFF_FFFF);
    drive(64'h0000_0F00_0000_0F00);
    drain();

    // Lock acquisition over five in-threshold errors, loss on +3
    csr_tdc_target   = 6'd20;
    csr_tdc_lock_thr = 6'd2;
    csr_tdc_lock_cnt = 8'd5;
    drive(therm(21));
    drive(therm(18));
    drive(therm(20));
    drive(therm(21));
    drive(therm(22));
    drive(therm(23));
    repeat (5) drive(therm(22));

    // Enable dropped mid-stream for three cycles, then resumed
    repeat (3) en_low();
    repeat (8) drive(therm(22));

    // Asynchronous reset between edges with three tokens in flight
    #3;
    csr_tdc_rst = 1'b1;
    #1;
    chk("rst_valid", 32'(tdc_valid), 32'd0);
    chk("rst_err", 32'(tdc_err), 32'd0);
    chk("rst_phase", 32'(tdc_phase_err), 32'd0);
    chk("rst_lock", 32'(tdc_lock), 32'd0);
    q.delete();
    model_phase = '0;
    model_cnt   = 0;
    model_lock  = 1'b0;
    tick();
    csr_tdc_rst = 1'b0;
    repeat (5) drive(therm(21));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
